load_store_unit: RTL and testbench
==================================

# load_store_unit

Memory-stage load/store unit between the CPU execute stage and the word-wide data RAM. Accepts one load or store request at a time and drives the RAM's word address, write data and read/write strobes. Performs byte-lane extraction with sign/zero extension for loads. Performs read-modify-write for byte and halfword stores, because the RAM only writes whole words.

## Interface
Parameters:
- `ADDR_W`, 32: request address width.

Ports (reset is synchronous and active-high):
- `Clock`  in  1  single clock; everything is on the rising edge.
- `Reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  unit can accept; reset value 1.
- `req_write`  in  1  1 = store, 0 = load.
- `req_size`  in  2  00 byte, 01 half, 10 word, 11 reserved.
- `req_signed`  in  1  load sign-extends when 1; ignored for stores.
- `req_addr`  in  ADDR_W  byte address.
- `req_wdata`  in  32  store data, right-aligned.
- `resp_valid`  out  1  one-cycle completion pulse; reset value 0.
- `resp_err`  out  1  misaligned or reserved size; valid with `resp_valid`; reset value 0.
- `resp_rdata`  out  32  formatted load data; 0 for stores and errors; reset value 0.
- `ram_addr`  out  32  `{req_addr[31:2],2'b00}` of the held request; reset value 0.
- `ram_datain`  out  32  word written to RAM; reset value 0.
- `ram_write`  out  1  RAM write strobe; reset value 0.
- `ram_read`  out  1  RAM read enable; reset value 0.
- `ram_dataout`  in  32  combinational RAM read data, valid in the same cycle as `ram_read`.

## Operation
States:
- IDLE: `req_ready`=1.
- LOAD: `ram_read`=1; the formatted word is registered into `resp_rdata`.
- STORE: `ram_write`=1, `ram_datain`=`req_wdata`.
- RMW_RD: `ram_read`=1; `ram_dataout` is captured into the merge register.
- RMW_WR: `ram_write`=1, `ram_datain`=merged word.
- DONE: `resp_valid`=1.

Transitions:
- IDLE to next state when `req_valid`: request fields are latched and `req_ready` drops.
- Error check at accept: size 11, half with `addr[0]`=1, or word with `addr[1:0]`≠0. An error goes straight to DONE with `resp_err`=1 and no RAM access.
- Otherwise: a load goes to LOAD; a word store goes to STORE; a byte or half store goes to RMW_RD and then RMW_WR.
- LOAD, STORE and RMW_WR go to DONE. DONE goes to IDLE.
- `req_ready` is high only in IDLE. No back-to-back acceptance from DONE.

Data formatting:
- Byte lanes are little-endian: lane k is bits [8k+7:8k] and is selected by `addr[1:0]`.
- A halfword uses lanes {1,0} or {3,2}.
- Load result: the selected lane(s) shifted to bit 0. When `req_signed`, bit 7 (byte) or bit 15 (half) is replicated into the upper bits; otherwise the upper bits are zero.
- Store merge: only the selected lane(s) of the read word are replaced by `req_wdata[7:0]` or `req_wdata[15:0]`. All other lanes are preserved bit-exact.

Reset and strobes:
- `ram_write` and `ram_read` are decoded from state and gated with `!Reset`. No RAM write occurs on an edge where `Reset`=1, even mid-RMW.
- Reset returns the FSM to IDLE and clears all outputs to the reset values listed above.
- A request presented while `Reset`=1 is dropped.

## Timing
Take the accept edge as the end of cycle T.
- Load: LOAD in T+1, `resp_valid` in T+2.
- Word store: write at the end of T+1, `resp_valid` in T+2.
- Sub-word store: read in T+1, write at the end of T+2, `resp_valid` in T+3.
- Error: `resp_valid`+`resp_err` in T+1.
- `resp_rdata` and `resp_err` hold their value until the next DONE.
- Maximum throughput: one word access per 3 cycles.

## Configuration
- `LSU_SUBWORD_EN` defined: byte and half accesses are supported as above.
- `LSU_SUBWORD_EN` undefined: RMW_RD, RMW_WR and the lane logic are removed. Any `req_size`≠10 completes as an error, with `resp_valid` in T+1 and no RAM access.

## Structure
- Package `lsu_pkg`: size encodings `SZ_BYTE`/`SZ_HALF`/`SZ_WORD`, the state enum, and the function computing the misalignment predicate.
- Sub-module `lsu_align`: purely combinational load extract/extend and store merge.
- The FSM and registers stay in the top module.

## Test plan
- Word store 0xDEADBEEF to 0x10, then word load from 0x10 → `resp_rdata`=0xDEADBEEF, `resp_err`=0, `resp_valid` 2 cycles after each accept.
- RAM word 0x11223344 at 0x20:
  - signed byte load from 0x23 → 0x00000011;
  - signed byte load from 0x21 → 0x00000033;
  - after writing 0x000080FF, signed half load from 0x20 → 0xFFFF80FF, unsigned → 0x000080FF.
- RAM word 0x11223344 at 0x30; byte store 0xAB to 0x31 → RAM word 0x1122AB44; `ram_write` high in exactly one cycle (T+2).
- Half load from 0x41, and word store to 0x42 → `resp_err`=1 in T+1, `ram_read`/`ram_write` never asserted, RAM unchanged.
- `Reset` asserted during RMW_WR of a byte store → no write at that edge, RAM word unchanged, next cycle `req_ready`=1, `resp_valid`=0.
- Built without `LSU_SUBWORD_EN`: byte load from 0x00 → `resp_err`=1 in T+1 with no RAM access; word accesses unchanged.

Source files
------------

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store unit.
//   - SZ_BYTE / SZ_HALF / SZ_WORD : req_size encodings (2'b11 is reserved)
//   - lsu_state_e                 : FSM state encoding
//   - lsu_misaligned()            : access-error predicate (misaligned or reserved size)
package lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_STORE,
        ST_RMW_RD,
        ST_RMW_WR,
        ST_DONE
    } lsu_state_e;

    // True when the access cannot be performed: reserved size, a halfword on
    // an odd byte, or a word not on a 4-byte boundary. Bytes never fault.
    function automatic logic lsu_misaligned(input logic [1:0] size, input logic [1:0] off);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = off[0];
            SZ_WORD: bad = (off != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational byte-lane logic for the load/store unit.
//   word_i    in  32  word read from RAM
//   size_i    in  2   access size (SZ_BYTE / SZ_HALF / SZ_WORD)
//   signed_i  in  1   sign-extend loaded byte/half
//   off_i     in  2   byte offset within the word (addr[1:0])
//   wdata_i   in  32  right-aligned store data
//   load_o    out 32  selected lane(s) shifted to bit 0 and extended
//   merge_o   out 32  word_i with the selected lane(s) replaced by store data
module lsu_align
    import lsu_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  size_i,
    input  logic        signed_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] load_o,
    output logic [31:0] merge_o
);

    logic [31:0] shifted;

    // Little-endian: lane k lives at bits [8k+7:8k], so shifting right by
    // 8*offset brings the addressed lane down to bit 0.
    assign shifted = word_i >> {off_i, 3'b000};

    always_comb begin
        load_o = word_i;
        case (size_i)
            SZ_BYTE: load_o = {{24{signed_i & shifted[7]}}, shifted[7:0]};
            SZ_HALF: load_o = {{16{signed_i & shifted[15]}}, shifted[15:0]};
            default: load_o = word_i;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            localparam logic [1:0] LANE = 2'(gi);
            logic       sel;
            logic [7:0] src;

            // A halfword covers lanes {1,0} or {3,2}; off_i[1] picks the pair
            // and the low/high byte of the store data maps onto the even/odd lane.
            always_comb begin
                sel = 1'b1;
                src = wdata_i[8*gi +: 8];
                case (size_i)
                    SZ_BYTE: begin
                        sel = (off_i == LANE);
                        src = wdata_i[7:0];
                    end
                    SZ_HALF: begin
                        sel = (off_i[1] == LANE[1]);
                        src = wdata_i[8*(gi%2) +: 8];
                    end
                    default: begin
                        sel = 1'b1;
                        src = wdata_i[8*gi +: 8];
                    end
                endcase
            end

            assign merge_o[8*gi +: 8] = sel ? src : word_i[8*gi +: 8];
        end
    endgenerate

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: memory-stage load/store unit in front of a word-wide RAM.
// Accepts one request at a time, formats load data (lane select, sign/zero
// extend) and performs read-modify-write for byte/halfword stores.
//
// Build option: define LSU_SUBWORD_EN to support byte/halfword accesses.
// Without it, only aligned word accesses are performed; every other size
// completes as an error with no RAM access.
//
// Ports:
//   Clock, Reset            clock, synchronous active-high reset
//   req_valid/req_ready     request handshake (ready only in IDLE)
//   req_write, req_size, req_signed, req_addr, req_wdata   request fields
//   resp_valid              one-cycle completion pulse
//   resp_err, resp_rdata    status/load data, held until the next completion
//   ram_addr, ram_datain, ram_write, ram_read, ram_dataout RAM side
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic              resp_err,
    output logic [31:0]       resp_rdata,
    output logic [31:0]       ram_addr,
    output logic [31:0]       ram_datain,
    output logic              ram_write,
    output logic              ram_read,
    input  logic [31:0]       ram_dataout
);

    lsu_state_e        state_q, state_d;
    logic [1:0]        size_q, size_d;
    logic              signed_q, signed_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;

    logic              accept_err;
    logic [31:0]       load_fmt;
    logic [31:0]       merged;
    logic [31:0]       addr_ext;

    generate
        if (ADDR_W >= 32) begin : g_addr_trunc
            assign addr_ext = addr_q[31:0];
        end else begin : g_addr_zext
            assign addr_ext = {{(32-ADDR_W){1'b0}}, addr_q};
        end
    endgenerate

`ifdef LSU_SUBWORD_EN
    logic [31:0] merge_q, merge_d;

    assign accept_err = lsu_misaligned(req_size, req_addr[1:0]);

    lsu_align u_align (
        .word_i   (state_q == ST_RMW_WR ? merge_q : ram_dataout),
        .size_i   (size_q),
        .signed_i (signed_q),
        .off_i    (addr_q[1:0]),
        .wdata_i  (wdata_q),
        .load_o   (load_fmt),
        .merge_o  (merged)
    );
`else
    // Word-only build: anything other than an aligned word is an error.
    assign accept_err = (req_size != SZ_WORD) || (req_addr[1:0] != 2'b00);
    assign load_fmt   = ram_dataout;
    assign merged     = 32'h0;
`endif

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q  <= ST_IDLE;
            size_q   <= 2'b00;
            signed_q <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= 32'h0;
            rdata_q  <= 32'h0;
            err_q    <= 1'b0;
`ifdef LSU_SUBWORD_EN
            merge_q  <= 32'h0;
`endif
        end else begin
            state_q  <= state_d;
            size_q   <= size_d;
            signed_q <= signed_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
`ifdef LSU_SUBWORD_EN
            merge_q  <= merge_d;
`endif
        end
    end

    // Response registers only change on the edge that enters DONE, so they
    // hold their value from one completion to the next.
    always_comb begin
        state_d  = state_q;
        size_d   = size_q;
        signed_d = signed_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
`ifdef LSU_SUBWORD_EN
        merge_d  = merge_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    size_d   = req_size;
                    signed_d = req_signed;
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    if (accept_err) begin
                        state_d = ST_DONE;
                        err_d   = 1'b1;
                        rdata_d = 32'h0;
                    end else if (!req_write) begin
                        state_d = ST_LOAD;
                    end else if (req_size == SZ_WORD) begin
                        state_d = ST_STORE;
                    end else begin
`ifdef LSU_SUBWORD_EN
                        state_d = ST_RMW_RD;
`else
                        state_d = ST_DONE;
                        err_d   = 1'b1;
                        rdata_d = 32'h0;
`endif
                    end
                end
            end
            ST_LOAD: begin
                state_d = ST_DONE;
                err_d   = 1'b0;
                rdata_d = load_fmt;
            end
            ST_STORE: begin
                state_d = ST_DONE;
                err_d   = 1'b0;
                rdata_d = 32'h0;
            end
`ifdef LSU_SUBWORD_EN
            ST_RMW_RD: begin
                state_d = ST_RMW_WR;
                merge_d = ram_dataout;
            end
            ST_RMW_WR: begin
                state_d = ST_DONE;
                err_d   = 1'b0;
                rdata_d = 32'h0;
            end
`endif
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Strobes are gated with Reset so an in-flight write is suppressed on the
    // very edge where reset is sampled.
    always_comb begin
        ram_datain = 32'h0;
        case (state_q)
            ST_STORE:  ram_datain = wdata_q;
            ST_RMW_WR: ram_datain = merged;
            default:   ram_datain = 32'h0;
        endcase
    end

    assign req_ready  = (state_q == ST_IDLE);
    assign resp_valid = (state_q == ST_DONE);
    assign resp_err   = err_q;
    assign resp_rdata = rdata_q;
    assign ram_addr   = {addr_ext[31:2], 2'b00};
    assign ram_read   = ((state_q == ST_LOAD) || (state_q == ST_RMW_RD)) && !Reset;
    assign ram_write  = ((state_q == ST_STORE) || (state_q == ST_RMW_WR)) && !Reset;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed testbench for load_store_unit with a small word RAM model.
module tb_load_store_unit;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_rdata;
    logic [31:0] ram_addr;
    logic [31:0] ram_datain;
    logic        ram_write;
    logic        ram_read;
    logic [31:0] ram_dataout;

    always #5 Clock = ~Clock;

    load_store_unit #(.ADDR_W(32)) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_size    (req_size),
        .req_signed  (req_signed),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .resp_valid  (resp_valid),
        .resp_err    (resp_err),
        .resp_rdata  (resp_rdata),
        .ram_addr    (ram_addr),
        .ram_datain  (ram_datain),
        .ram_write   (ram_write),
        .ram_read    (ram_read),
        .ram_dataout (ram_dataout)
    );

    // RAM model: combinational read, write on the rising edge. The bench
    // preloads words through its own port while the DUT is idle.
    logic [31:0] mem [0:63];
    logic        tb_we = 1'b0;
    logic [5:0]  tb_widx = 6'd0;
    logic [31:0] tb_wdat = 32'h0;

    always @(posedge Clock) begin
        if (ram_write) mem[ram_addr[7:2]] <= ram_datain;
        else if (tb_we) mem[tb_widx] <= tb_wdat;
    end
    assign ram_dataout = mem[ram_addr[7:2]];

    int checks = 0;
    int errors = 0;

    // Per-transaction observations filled by run_req
    int          r_lat;
    int          r_reads;
    int          r_writes;
    int          r_wcyc;
    logic        r_done;
    logic        r_badaddr;
    logic        r_ready;
    logic        r_err;
    logic [31:0] r_rdata;

`ifdef LSU_SUBWORD_EN
    localparam int RST_DELAY = 2;
`else
    localparam int RST_DELAY = 1;
`endif

    task automatic poke(input int idx, input logic [31:0] data);
        @(negedge Clock);
        tb_we   = 1'b1;
        tb_widx = 6'(idx);
        tb_wdat = data;
        @(posedge Clock);
        #1 tb_we = 1'b0;
    endtask

    // Presents one request, then watches the cycles after the accept edge.
    task automatic run_req(input logic wr, input logic [1:0] sz, input logic sg,
                           input logic [31:0] ad, input logic [31:0] wd);
        @(negedge Clock);
        req_valid  = 1'b1;
        req_write  = wr;
        req_size   = sz;
        req_signed = sg;
        req_addr   = ad;
        req_wdata  = wd;
        @(posedge Clock);
        #1 req_valid = 1'b0;
        r_lat = 0; r_reads = 0; r_writes = 0; r_wcyc = 0;
        r_done = 1'b0; r_badaddr = 1'b0; r_ready = 1'b0; r_err = 1'b0; r_rdata = 32'h0;
        for (int c = 1; c <= 20 && !r_done; c++) begin
            @(negedge Clock);
            if (ram_read) r_reads++;
            if (ram_write) begin
                r_writes++;
                r_wcyc = c;
            end
            if ((ram_read || ram_write) && ram_addr !== {ad[31:2], 2'b00}) r_badaddr = 1'b1;
            if (resp_valid) begin
                r_done  = 1'b1;
                r_lat   = c;
                r_rdata = resp_rdata;
                r_err   = resp_err;
                r_ready = req_ready;
            end
        end
        if (!r_done) begin
            checks++;
            errors++;
            $display("FAIL timeout addr=%h: no resp_valid within 20 cycles", ad);
        end
        $display("req wr=%0d size=%0d signed=%0d addr=%h wdata=%h -> lat=%0d err=%0d rdata=%h reads=%0d writes=%0d",
                 wr, sz, sg, ad, wd, r_lat, r_err, r_rdata, r_reads, r_writes);
    endtask

    task automatic test_reset;
        Reset = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00; req_signed = 1'b0;
        req_addr = 32'h0; req_wdata = 32'h0;
        poke(5, 32'hCAFEF00D);
        // A store presented during reset must be dropped.
        @(negedge Clock);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'b10;
        req_addr = 32'h14; req_wdata = 32'h12345678;
        repeat (3) @(negedge Clock);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", req_ready); end
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", resp_valid); end
        checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", resp_err); end
        checks++; if (resp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h want 0", resp_rdata); end
        checks++; if (ram_addr !== 32'h0) begin errors++; $display("FAIL reset_ram_addr got %h want 0", ram_addr); end
        checks++; if (ram_datain !== 32'h0) begin errors++; $display("FAIL reset_ram_datain got %h want 0", ram_datain); end
        checks++; if ({ram_read, ram_write} !== 2'b00) begin errors++; $display("FAIL reset_strobes got %b want 00", {ram_read, ram_write}); end
        req_valid = 1'b0;
        Reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge Clock);
            checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_drop_valid cycle %0d got %b want 0", c, resp_valid); end
        end
        checks++; if (mem[5] !== 32'hCAFEF00D) begin errors++; $display("FAIL reset_drop_mem got %h want cafef00d", mem[5]); end
        $display("test_reset done");
    endtask

    task automatic test_word;
        run_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
        checks++; if (r_lat !== 2) begin errors++; $display("FAIL wst_latency got %0d want 2", r_lat); end
        checks++; if (r_err !== 1'b0) begin errors++; $display("FAIL wst_err got %b want 0", r_err); end
        checks++; if (r_rdata !== 32'h0) begin errors++; $display("FAIL wst_rdata got %h want 0", r_rdata); end
        checks++; if (r_writes !== 1 || r_reads !== 0) begin errors++; $display("FAIL wst_strobes got w=%0d r=%0d want w=1 r=0", r_writes, r_reads); end
        checks++; if (r_badaddr !== 1'b0) begin errors++; $display("FAIL wst_ram_addr got bad want 00000010"); end
        checks++; if (mem[4] !== 32'hDEADBEEF) begin errors++; $display("FAIL wst_mem got %h want deadbeef", mem[4]); end
        checks++; if (r_ready !== 1'b0) begin errors++; $display("FAIL done_ready got %b want 0", r_ready); end

        run_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        checks++; if (r_lat !== 2) begin errors++; $display("FAIL wld_latency got %0d want 2", r_lat); end
        checks++; if (r_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL wld_rdata got %h want deadbeef", r_rdata); end
        checks++; if (r_err !== 1'b0) begin errors++; $display("FAIL wld_err got %b want 0", r_err); end
        checks++; if (r_reads !== 1 || r_writes !== 0) begin errors++; $display("FAIL wld_strobes got r=%0d w=%0d want r=1 w=0", r_reads, r_writes); end
        checks++; if (r_badaddr !== 1'b0) begin errors++; $display("FAIL wld_ram_addr got bad want 00000010"); end
        // Response holds after the DONE pulse.
        @(negedge Clock);
        checks++; if (resp_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL wld_hold got %h want deadbeef", resp_rdata); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL idle_ready got %b want 1", req_ready); end
    endtask

    task automatic test_errors;
        logic [1:0]  szs [3];
        logic        wrs [3];
        logic [31:0] ads [3];
        szs[0] = 2'b01; wrs[0] = 1'b0; ads[0] = 32'h41;
        szs[1] = 2'b10; wrs[1] = 1'b1; ads[1] = 32'h42;
        szs[2] = 2'b11; wrs[2] = 1'b0; ads[2] = 32'h40;
        poke(16, 32'h0BADF00D);
        for (int i = 0; i < 3; i++) begin
            run_req(wrs[i], szs[i], 1'b1, ads[i], 32'h55AA55AA);
            checks++; if (r_lat !== 1) begin errors++; $display("FAIL err%0d_latency got %0d want 1", i, r_lat); end
            checks++; if (r_err !== 1'b1) begin errors++; $display("FAIL err%0d_err got %b want 1", i, r_err); end
            checks++; if (r_rdata !== 32'h0) begin errors++; $display("FAIL err%0d_rdata got %h want 0", i, r_rdata); end
            checks++; if (r_reads !== 0 || r_writes !== 0) begin errors++; $display("FAIL err%0d_strobes got r=%0d w=%0d want 0 0", i, r_reads, r_writes); end
            checks++; if (mem[16] !== 32'h0BADF00D) begin errors++; $display("FAIL err%0d_mem got %h want 0badf00d", i, mem[16]); end
        end
        // A good access after an error clears resp_err.
        run_req(1'b0, 2'b10, 1'b0, 32'h40, 32'h0);
        checks++; if (r_err !== 1'b0 || r_rdata !== 32'h0BADF00D) begin errors++; $display("FAIL err_clear got err=%b rdata=%h want 0 0badf00d", r_err, r_rdata); end
    endtask

    task automatic test_subword;
`ifdef LSU_SUBWORD_EN
        poke(8, 32'h11223344);
        run_req(1'b0, 2'b00, 1'b1, 32'h23, 32'h0);
        checks++; if (r_rdata !== 32'h00000011 || r_lat !== 2) begin errors++; $display("FAIL lb_23 got %h lat %0d want 00000011 lat 2", r_rdata, r_lat); end
        run_req(1'b0, 2'b00, 1'b1, 32'h21, 32'h0);
        checks++; if (r_rdata !== 32'h00000033) begin errors++; $display("FAIL lb_21 got %h want 00000033", r_rdata); end
        poke(8, 32'h000080FF);
        run_req(1'b0, 2'b00, 1'b1, 32'h20, 32'h0);
        checks++; if (r_rdata !== 32'hFFFFFFFF) begin errors++; $display("FAIL lb_20_signed got %h want ffffffff", r_rdata); end
        run_req(1'b0, 2'b01, 1'b1, 32'h20, 32'h0);
        checks++; if (r_rdata !== 32'hFFFF80FF) begin errors++; $display("FAIL lh_signed got %h want ffff80ff", r_rdata); end
        run_req(1'b0, 2'b01, 1'b0, 32'h20, 32'h0);
        checks++; if (r_rdata !== 32'h000080FF) begin errors++; $display("FAIL lh_unsigned got %h want 000080ff", r_rdata); end
        run_req(1'b0, 2'b01, 1'b1, 32'h22, 32'h0);
        checks++; if (r_rdata !== 32'h00000000) begin errors++; $display("FAIL lh_upper got %h want 00000000", r_rdata); end

        poke(12, 32'h11223344);
        run_req(1'b1, 2'b00, 1'b0, 32'h31, 32'hFFFFFFAB);
        checks++; if (mem[12] !== 32'h1122AB44) begin errors++; $display("FAIL sb_mem got %h want 1122ab44", mem[12]); end
        checks++; if (r_writes !== 1 || r_wcyc !== 2) begin errors++; $display("FAIL sb_write got n=%0d cyc=%0d want n=1 cyc=2", r_writes, r_wcyc); end
        checks++; if (r_lat !== 3 || r_reads !== 1) begin errors++; $display("FAIL sb_timing got lat=%0d reads=%0d want 3 1", r_lat, r_reads); end
        run_req(1'b1, 2'b01, 1'b0, 32'h32, 32'hCDEF1234);
        checks++; if (mem[12] !== 32'h1234AB44) begin errors++; $display("FAIL sh_mem got %h want 1234ab44", mem[12]); end
`else
        poke(0, 32'h76543210);
        run_req(1'b0, 2'b00, 1'b0, 32'h00, 32'h0);
        checks++; if (r_lat !== 1 || r_err !== 1'b1) begin errors++; $display("FAIL nosub_lb got lat=%0d err=%b want 1 1", r_lat, r_err); end
        checks++; if (r_reads !== 0 || r_writes !== 0) begin errors++; $display("FAIL nosub_lb_strobes got r=%0d w=%0d want 0 0", r_reads, r_writes); end
        run_req(1'b1, 2'b01, 1'b0, 32'h00, 32'h0000FFFF);
        checks++; if (r_lat !== 1 || r_err !== 1'b1 || r_writes !== 0) begin errors++; $display("FAIL nosub_sh got lat=%0d err=%b w=%0d want 1 1 0", r_lat, r_err, r_writes); end
        checks++; if (mem[0] !== 32'h76543210) begin errors++; $display("FAIL nosub_mem got %h want 76543210", mem[0]); end
`endif
    endtask

    // Reset lands on the final write cycle of a store (RMW_WR, or STORE in
    // the word-only build); the write must be suppressed.
    task automatic test_reset_mid;
        poke(20, 32'h11223344);
        @(negedge Clock);
        req_valid = 1'b1; req_write = 1'b1; req_signed = 1'b0;
        req_addr = 32'h51; req_wdata = 32'h00000055;
`ifdef LSU_SUBWORD_EN
        req_size = 2'b00;
`else
        req_size = 2'b10;
        req_addr = 32'h50;
`endif
        @(posedge Clock);
        #1 req_valid = 1'b0;
        repeat (RST_DELAY) @(negedge Clock);
        checks++; if (ram_write !== 1'b1) begin errors++; $display("FAIL mid_pre_write got %b want 1", ram_write); end
        Reset = 1'b1;
        #1;
        checks++; if (ram_write !== 1'b0) begin errors++; $display("FAIL mid_gated_write got %b want 0", ram_write); end
        @(posedge Clock);
        #1 Reset = 1'b0;
        @(negedge Clock);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL mid_ready got %b want 1", req_ready); end
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL mid_valid got %b want 0", resp_valid); end
        checks++; if (mem[20] !== 32'h11223344) begin errors++; $display("FAIL mid_mem got %h want 11223344", mem[20]); end
        $display("test_reset_mid done");
    endtask

    task automatic test_back_to_back;
        run_req(1'b1, 2'b10, 1'b0, 32'h60, 32'hA5A5_0F0F);
        run_req(1'b0, 2'b10, 1'b0, 32'h60, 32'h0);
        checks++; if (r_rdata !== 32'hA5A50F0F || r_lat !== 2) begin errors++; $display("FAIL b2b_load got %h lat %0d want a5a50f0f lat 2", r_rdata, r_lat); end
        checks++; if (mem[24] !== 32'hA5A50F0F) begin errors++; $display("FAIL b2b_mem got %h want a5a50f0f", mem[24]); end
    endtask

    initial begin
        test_reset;
        test_word;
        test_errors;
        test_subword;
        test_reset_mid;
        test_back_to_back;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
